// File: rtl/wb_arb_pkg.sv
// Shared encodings for the register-file write-back arbiter.
// Also carries the saturating burst-counter step used by the top level.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Saturates at 3 so a long solo run by one requester cannot wrap back
  // to 0 and hand it a fresh burst when the other requester shows up.
  function automatic logic [1:0] burst_next(input logic [1:0] cnt);
    return (cnt == 2'd3) ? cnt : cnt + 2'd1;
  endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational grant decision for the write-back arbiter.
// WB_FIXED_PRIO_EN selects fixed A-over-B priority instead of bounded-burst round-robin.
module wb_arb_pick
  import wb_arb_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  state_t     state,
  input  logic [1:0] cnt,
  input  logic       last,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       block,
  output logic       gnt_a,
  output logic       gnt_b
);

`ifdef WB_FIXED_PRIO_EN
  logic unused_rr;
  assign unused_rr = ^{state, cnt, last};

  assign gnt_a = req_a & ~block;
  assign gnt_b = req_b & ~req_a & ~block;
`else
  localparam logic [2:0] CNT_LIM = 3'(BURST_MAX - 1);

  logic under_lim;
  assign under_lim = {1'b0, cnt} < CNT_LIM;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!block) begin
      if (req_a && !req_b) begin
        gnt_a = 1'b1;
      end else if (req_b && !req_a) begin
        gnt_b = 1'b1;
      end else if (req_a && req_b) begin
        case (state)
          ST_OWN_A: if (under_lim) gnt_a = 1'b1; else gnt_b = 1'b1;
          ST_OWN_B: if (under_lim) gnt_b = 1'b1; else gnt_a = 1'b1;
          // From idle, contention goes to whoever was not served last.
          default:  if (last == SEL_B) gnt_a = 1'b1; else gnt_b = 1'b1;
        endcase
      end
    end
  end
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B) results.
// Define WB_FIXED_PRIO_EN for fixed A priority; default is bounded-burst round-robin.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_b,
  output logic              mux_sel,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  // Handshake: a write moves on a rising edge with req_x && gnt_x; the
  // requester holds req/addr/data until then, and grants never go high
  // without the matching request, together, or during stall/reset.

  state_t      state, state_n;
  logic [1:0]  burst_cnt, burst_cnt_n;
  logic        last_gnt, last_gnt_n;
  logic        any_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  wb_arb_pick #(.BURST_MAX(BURST_MAX)) u_pick (
    .state (state),
    .cnt   (burst_cnt),
    .last  (last_gnt),
    .req_a (req_a),
    .req_b (req_b),
    .block (stall | rst),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  assign mux_sel  = gnt_b;
  assign any_gnt  = gnt_a | gnt_b;
  assign sel_addr = (mux_sel == SEL_B) ? addr_b : addr_a;
  assign sel_data = (mux_sel == SEL_B) ? data_b : data_a;

  always_comb begin
    state_n     = state;
    burst_cnt_n = burst_cnt;
    last_gnt_n  = last_gnt;
    if (gnt_a) begin
      state_n     = ST_OWN_A;
      burst_cnt_n = (state == ST_OWN_A) ? burst_next(burst_cnt) : 2'd0;
      last_gnt_n  = SEL_A;
    end else if (gnt_b) begin
      state_n     = ST_OWN_B;
      burst_cnt_n = (state == ST_OWN_B) ? burst_next(burst_cnt) : 2'd0;
      last_gnt_n  = SEL_B;
    end else begin
      // An idle or stalled cycle ends the burst but keeps the fairness pointer.
      state_n     = ST_IDLE;
      burst_cnt_n = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      burst_cnt <= 2'd0;
      last_gnt  <= SEL_B;
    end else begin
      state     <= state_n;
      burst_cnt <= burst_cnt_n;
      last_gnt  <= last_gnt_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= any_gnt;
      if (any_gnt) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, single writes, contention bursts,
// stall recovery and the idle-gap pointer; fixed-priority checks under WB_FIXED_PRIO_EN.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        req_a, req_b;
  logic [2:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b;
  logic        gnt_a, gnt_b, mux_sel, wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;

  int tests  = 0;
  int failed = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .req_a   (req_a),
    .addr_a  (addr_a),
    .data_a  (data_a),
    .gnt_a   (gnt_a),
    .req_b   (req_b),
    .addr_b  (addr_b),
    .data_b  (data_b),
    .gnt_b   (gnt_b),
    .mux_sel (mux_sel),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic check_grants(input string tag, input logic ea, input logic eb);
    #1;
    check({tag, "_gnt_a"}, gnt_a, ea);
    check({tag, "_gnt_b"}, gnt_b, eb);
    check({tag, "_mux"}, mux_sel, eb);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    req_a = 1'b0; addr_a = '0; data_a = '0;
    req_b = 1'b0; addr_b = '0; data_b = '0;
    tick();
    tick();
    check("rst_gnt_a", gnt_a, 1'b0);
    rst = 1'b0;
    tick();
    check("init_wr_en", wr_en, 1'b0);
    check("init_wr_addr", wr_addr, 3'd0);
    check("init_wr_data", wr_data, 16'h0000);

    // Single requester A.
    req_a = 1'b1; addr_a = 3'd3; data_a = 16'hBEEF;
    check_grants("single", 1'b1, 1'b0);
    tick();
    req_a = 1'b0;
    check("single_wr_en", wr_en, 1'b1);
    check("single_wr_addr", wr_addr, 3'd3);
    check("single_wr_data", wr_data, 16'hBEEF);
    check_grants("single_drop", 1'b0, 1'b0);
    tick();
    check("idle_wr_en", wr_en, 1'b0);
    check("idle_wr_hold", wr_addr, 3'd3);

`ifndef WB_FIXED_PRIO_EN
    // Idle gap after an A grant: contention goes to B.
    req_a = 1'b1; addr_a = 3'd1; data_a = 16'h1111;
    req_b = 1'b1; addr_b = 3'd2; data_b = 16'h2222;
    check_grants("gap", 1'b0, 1'b1);
    tick();
    req_a = 1'b0; req_b = 1'b0;
    check("gap_wr_addr", wr_addr, 3'd2);
    check("gap_wr_data", wr_data, 16'h2222);
    tick();
`endif

    // Reset asserted mid-transfer.
    req_a = 1'b1; addr_a = 3'd4; data_a = 16'hCAFE;
    check_grants("pre_rst", 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_mid_gnt_a", gnt_a, 1'b0);
    tick();
    req_a = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", wr_addr, 3'd0);
    check("rst_wr_data", wr_data, 16'h0000);
    tick();

`ifndef WB_FIXED_PRIO_EN
    // Contention from reset: A,A,A,A,B,B,B,B,A,A.
    begin
      logic exp_b [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      pulse_reset();
      req_a = 1'b1; addr_a = 3'd5; data_a = 16'hAAAA;
      req_b = 1'b1; addr_b = 3'd6; data_b = 16'h5555;
      for (int i = 0; i < 10; i++) begin
        check_grants($sformatf("rr%0d", i), !exp_b[i], exp_b[i]);
        check("rr_excl", gnt_a & gnt_b, 1'b0);
        exp_q.push_back(exp_b[i] ? 16'h5555 : 16'hAAAA);
        tick();
        check("rr_wr_en", wr_en, 1'b1);
        check("rr_wr_data", wr_data, exp_q.pop_front());
      end
      req_a = 1'b0; req_b = 1'b0;
      tick();
    end

    // Stall after two A grants, then A restarts a full burst of four.
    pulse_reset();
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check_grants($sformatf("pre_stall%0d", i), 1'b1, 1'b0);
      tick();
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_grants($sformatf("stall%0d", i), 1'b0, 1'b0);
      tick();
      check("stall_wr_en", wr_en, 1'b0);
    end
    stall = 1'b0;
    req_b = 1'b0;
    check_grants("restart_solo", 1'b1, 1'b0);
    tick();
    req_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_grants($sformatf("restart%0d", i), 1'b1, 1'b0);
      tick();
    end
    check_grants("restart_handoff", 1'b0, 1'b1);
    tick();
    req_a = 1'b0; req_b = 1'b0;
    tick();
`else
    // Fixed priority: A wins every contended cycle; B only once A drops.
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_grants($sformatf("fix%0d", i), 1'b1, 1'b0);
      tick();
    end
    req_a = 1'b0;
    check_grants("fix_drop", 1'b0, 1'b1);
    tick();
    req_b = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
